pit_channel: RTL and testbench

Single-channel slice of an 8254-style programmable interval timer: CPU bus interface, control word register and one 16-bit down-counter with modes 0–5, all clocked from one clock. It sits behind the system 8-bit data bus. Three instances (COUNTER_ID 0..2) plus a shared address decode form a full timer.

---
 rtl/pit_channel.sv | 218 +++++++++++++++++++++
 tb/tb_pit_channel.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pit_channel.sv
// pit_channel: one 8254-style counter channel with its bus interface and control word.
// Counting is binary only; the BCD flag is held so the control word is stored whole.
module pit_channel #(
    parameter logic [1:0] COUNTER_ID = 2'b00
) (
    input  logic       clk,
    input  logic       _rst,
    inout  wire  [7:0] D,
    input  logic       _WR,
    input  logic       _RD,
    input  logic       _CS,
    input  logic [1:0] A,
    input  logic       GATE,
    output logic       OUT
);
    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e      state_q, state_d;
    logic [1:0]  rw_q, rw_d;
    logic [2:0]  mode_q, mode_d;
    logic        bcd_q, bcd_d;
    logic [15:0] cr_q, cr_d, ce_q, ce_d, ol_q, ol_d;
    logic        latched_q, latched_d;
    logic        wr_msb_q, wr_msb_d, rd_msb_q, rd_msb_d;
    logic        valid_q, valid_d;
    logic        out_q, out_d;
    logic        wr_prev_q, rd_prev_q, gate_q, gate_qq;

    logic        wr_cond, rd_cond, wr_pulse, rd_done, gate_rise;
    logic        cw_wr, cnt_wr, cnt_done;
    logic [2:0]  cw_mode;
    logic [15:0] ce_dec, half, rd_val;
    logic [7:0]  rd_byte;
    logic        unused_bcd;

    assign wr_cond   = !_CS && !_WR && _RD;
    assign rd_cond   = !_CS && !_RD && _WR && (A == COUNTER_ID);
    assign wr_pulse  = wr_cond && !wr_prev_q;
    assign rd_done   = rd_prev_q && !rd_cond;
    assign gate_rise = gate_q && !gate_qq;
    assign cw_wr     = wr_pulse && (A == 2'b11) && (D[7:6] == COUNTER_ID);
    assign cnt_wr    = wr_pulse && (A == COUNTER_ID);
    assign cnt_done  = cnt_wr && ((rw_q != 2'b11) || wr_msb_q);
    // Modes 6/7 fold onto 2/3 so the counting logic only ever sees 0..5.
    assign cw_mode   = (D[3:2] == 2'b11) ? {1'b0, D[2:1]} : D[3:1];
    assign ce_dec    = ce_q - 16'd1;
    // Mode 3 drops OUT when CE reaches half the reload value; count 0 means 65536.
    assign half      = (cr_q == 16'd0) ? 16'h8000 : {1'b0, cr_q[15:1]};
    assign rd_val    = latched_q ? ol_q : ce_q;
    assign unused_bcd = bcd_q;

    always_comb begin
        rd_byte = rd_val[7:0];
        unique case (rw_q)
            2'b10:   rd_byte = rd_val[15:8];
            2'b11:   rd_byte = rd_msb_q ? rd_val[15:8] : rd_val[7:0];
            default: rd_byte = rd_val[7:0];
        endcase
    end

    assign D   = rd_cond ? rd_byte : 8'hzz;
    assign OUT = out_q;

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        mode_d    = mode_q;
        bcd_d     = bcd_q;
        cr_d      = cr_q;
        ce_d      = ce_q;
        ol_d      = ol_q;
        latched_d = latched_q;
        wr_msb_d  = wr_msb_q;
        rd_msb_d  = rd_msb_q;
        valid_d   = valid_q;
        out_d     = out_q;

        case (state_q)
            StLoad: begin
                ce_d    = cr_q;
                state_d = StRun;
            end
            StRun: begin
                case (mode_q)
                    3'd0: if (GATE) begin
                        ce_d = ce_dec;
                        if (ce_q == 16'd1) out_d = 1'b1;
                    end
                    3'd1: begin
                        ce_d = ce_dec;
                        if (ce_q == 16'd1) out_d = 1'b1;
                    end
                    3'd2: if (!GATE) begin
                        out_d = 1'b1;
                    end else if (ce_q == 16'd1) begin
                        ce_d  = cr_q;
                        out_d = 1'b1;
                    end else begin
                        ce_d  = ce_dec;
                        out_d = (ce_q != 16'd2);
                    end
                    3'd3: if (!GATE) begin
                        out_d = 1'b1;
                    end else if (ce_q == 16'd1) begin
                        ce_d  = cr_q;
                        out_d = 1'b1;
                    end else begin
                        ce_d = ce_dec;
                        if (ce_dec == half) out_d = 1'b0;
                    end
                    3'd4: begin
                        out_d = 1'b1;
                        if (GATE) begin
                            ce_d = ce_dec;
                            if (ce_q == 16'd1) out_d = 1'b0;
                        end
                    end
                    default: begin
                        ce_d  = ce_dec;
                        out_d = (ce_q != 16'd1);
                    end
                endcase
            end
            default: ;
        endcase

        if (gate_rise && valid_q && (mode_q != 3'd0) && (mode_q != 3'd4)) begin
            ce_d    = cr_q;
            state_d = StRun;
            out_d   = (mode_q != 3'd1);
        end

        if (cnt_wr) begin
            unique case (rw_q)
                2'b01:   cr_d = {8'h00, D};
                2'b10:   cr_d = {D, 8'h00};
                default: cr_d = wr_msb_q ? {D, cr_q[7:0]} : {cr_q[15:8], D};
            endcase
            wr_msb_d = (rw_q == 2'b11) && !wr_msb_q;
            if (mode_q == 3'd0) begin
                out_d   = 1'b0;
                state_d = StIdle;
            end
            if (cnt_done) begin
                valid_d = 1'b1;
                if ((mode_q == 3'd0) || (mode_q == 3'd4) ||
                    (((mode_q == 3'd2) || (mode_q == 3'd3)) && (state_q == StIdle))) begin
                    state_d = StLoad;
                end
            end
        end

        if (rd_done) begin
            if ((rw_q == 2'b11) && !rd_msb_q) begin
                rd_msb_d = 1'b1;
            end else begin
                rd_msb_d  = 1'b0;
                latched_d = 1'b0;
            end
        end

        if (cw_wr) begin
            if (D[5:4] == 2'b00) begin
                if (!latched_q) begin
                    ol_d      = ce_q;
                    latched_d = 1'b1;
                end
            end else begin
                rw_d     = D[5:4];
                mode_d   = cw_mode;
                bcd_d    = D[0];
                wr_msb_d = 1'b0;
                rd_msb_d = 1'b0;
                valid_d  = 1'b0;
                state_d  = StIdle;
                out_d    = (cw_mode != 3'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q   <= StIdle;
            rw_q      <= 2'b11;
            mode_q    <= 3'd0;
            bcd_q     <= 1'b0;
            cr_q      <= 16'd0;
            ce_q      <= 16'd0;
            ol_q      <= 16'd0;
            latched_q <= 1'b0;
            wr_msb_q  <= 1'b0;
            rd_msb_q  <= 1'b0;
            valid_q   <= 1'b0;
            out_q     <= 1'b0;
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
            gate_q    <= 1'b0;
            gate_qq   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            mode_q    <= mode_d;
            bcd_q     <= bcd_d;
            cr_q      <= cr_d;
            ce_q      <= ce_d;
            ol_q      <= ol_d;
            latched_q <= latched_d;
            wr_msb_q  <= wr_msb_d;
            rd_msb_q  <= rd_msb_d;
            valid_q   <= valid_d;
            out_q     <= out_d;
            wr_prev_q <= wr_cond;
            rd_prev_q <= rd_cond;
            gate_q    <= GATE;
            gate_qq   <= gate_q;
        end
    end
endmodule

// File: tb/tb_pit_channel.sv
// Directed bench for pit_channel: mode 0/1/2/3 waveforms, latch reads and ignored writes.
// The data bus is pulled up, so an undriven bus reads back as 8'hFF.
module tb_pit_channel;
    logic       clk;
    logic       rst_n;
    logic       wr_n, rd_n, cs_n;
    logic [1:0] a;
    logic       gate;
    logic       out;
    tri1  [7:0] d_bus;
    logic [7:0] drv_val;
    logic       drv_en;
    logic [7:0] rdata;
    int         n_cmp = 0;
    int         n_bad = 0;

    assign d_bus = drv_en ? drv_val : 8'hzz;

    pit_channel #(.COUNTER_ID(2'b00)) dut (
        .clk  (clk),
        ._rst (rst_n),
        .D    (d_bus),
        ._WR  (wr_n),
        ._RD  (rd_n),
        ._CS  (cs_n),
        .A    (a),
        .GATE (gate),
        .OUT  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge; the write is sampled on the next posedge, then released.
    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        a = addr; drv_val = data; drv_en = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1; drv_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
        a = addr; cs_n = 1'b0; rd_n = 1'b0;
        #2 data = d_bus;
        @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; wr_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
        a = 2'b00; gate = 1'b0; drv_en = 1'b0; drv_val = 8'h00;
        #2;
        check("rst_out", out, 1'b0);
        check("rst_bus_z", d_bus, 8'hFF);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        bus_read(2'b00, rdata); check("rst_ce_lsb", rdata, 8'h00);
        bus_read(2'b00, rdata); check("rst_ce_msb", rdata, 8'h00);

        // Mode 0, count 5: OUT rises at the 6th edge after the MSB write.
        gate = 1'b1;
        repeat (2) @(negedge clk);
        bus_write(2'b11, 8'h30);
        check("m0_cw_out", out, 1'b0);
        bus_write(2'b00, 8'h05);
        bus_write(2'b00, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("m0_out_k%0d", k), out, (k >= 6) ? 1'b1 : 1'b0);
            @(negedge clk);
        end

        // Mode 2, count 4: period 4, low on every 4th clock; GATE low freezes CE at 3.
        bus_write(2'b11, 8'h34);
        check("m2_cw_out", out, 1'b1);
        bus_write(2'b00, 8'h04);
        bus_write(2'b00, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            check($sformatf("m2_out_k%0d", k), out, (k % 4 == 0) ? 1'b0 : 1'b1);
            @(negedge clk);
        end
        gate = 1'b0;
        @(negedge clk); check("m2_gate_lo_out1", out, 1'b1);
        @(negedge clk); check("m2_gate_lo_out2", out, 1'b1);
        bus_read(2'b00, rdata); check("m2_frozen_lsb", rdata, 8'h03);
        bus_read(2'b00, rdata); check("m2_frozen_msb", rdata, 8'h00);
        gate = 1'b1;
        repeat (3) @(negedge clk);

        // Mode 3, count 5: 3 clocks high, 2 low.
        bus_write(2'b11, 8'h16);
        check("m3_cw_out", out, 1'b1);
        bus_write(2'b00, 8'h05);
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("m3_out_k%0d", k), out, (((k - 1) % 5) < 3) ? 1'b1 : 1'b0);
            @(negedge clk);
        end

        // Latch 0x1234 while mode 2 keeps counting, then read live CE (0x1229).
        bus_write(2'b11, 8'h34);
        bus_write(2'b00, 8'h34);
        bus_write(2'b00, 8'h12);
        bus_write(2'b11, 8'h00);
        repeat (5) @(negedge clk);
        bus_read(2'b00, rdata); check("latch_lsb", rdata, 8'h34);
        bus_read(2'b00, rdata); check("latch_msb", rdata, 8'h12);
        bus_read(2'b00, rdata); check("live_lsb", rdata, 8'h29);
        bus_read(2'b00, rdata); check("live_msb", rdata, 8'h12);

        // Mode 1, count 3: GATE pulse gives 3 clocks low; retrigger extends it.
        gate = 1'b0;
        repeat (2) @(negedge clk);
        bus_write(2'b11, 8'h12);
        check("m1_cw_out", out, 1'b1);
        bus_write(2'b00, 8'h03);
        repeat (2) @(negedge clk);
        check("m1_no_trig_out", out, 1'b1);
        gate = 1'b1;
        @(negedge clk); check("m1_trig_k0", out, 1'b1);
        gate = 1'b0;
        @(negedge clk); check("m1_trig_k1", out, 1'b0);
        @(negedge clk); check("m1_trig_k2", out, 1'b0);
        @(negedge clk); check("m1_trig_k3", out, 1'b0);
        @(negedge clk); check("m1_trig_k4", out, 1'b1);
        gate = 1'b1;
        @(negedge clk); check("m1_re_k0", out, 1'b1);
        gate = 1'b0;
        @(negedge clk); check("m1_re_k1", out, 1'b0);
        @(negedge clk); check("m1_re_k2", out, 1'b0);
        gate = 1'b1;
        @(negedge clk); check("m1_re_k3", out, 1'b0);
        gate = 1'b0;
        @(negedge clk); check("m1_re_extend", out, 1'b0);
        @(negedge clk); check("m1_re_k5", out, 1'b0);
        @(negedge clk); check("m1_re_k6", out, 1'b0);
        @(negedge clk); check("m1_re_end", out, 1'b1);

        // Other-counter and read-back control words change nothing; CE keeps wrapping down.
        bus_write(2'b11, 8'h70);
        check("ign_sc01_out", out, 1'b1);
        bus_write(2'b11, 8'hF0);
        check("ign_sc11_out", out, 1'b1);
        bus_read(2'b11, rdata); check("cw_read_z", rdata, 8'hFF);
        bus_read(2'b00, rdata); check("m1_wrap_lsb", rdata, 8'hFA);

        // Asynchronous reset mid-count.
        #2 rst_n = 1'b0;
        #1 check("async_rst_out", out, 1'b0);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        bus_read(2'b00, rdata); check("post_rst_lsb", rdata, 8'h00);
        bus_read(2'b00, rdata); check("post_rst_msb", rdata, 8'h00);
        check("post_rst_out", out, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
